pipe_stage_skid: RTL and testbench



---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_stage_skid_sat_counter.sv | 36 +++
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared occupancy encoding and per-stage bubble control values
//                for the generic inter-stage pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

    // Bubble control values for each stage boundary of the classic five-stage pipe
    localparam logic [9:0] c_IF_ID_NOP_CTRL  = 10'd0;
    localparam logic [9:0] c_ID_EX_NOP_CTRL  = 10'd0;
    localparam logic [9:0] c_EX_MEM_NOP_CTRL = 10'd0;
    localparam logic [9:0] c_MEM_WB_NOP_CTRL = 10'd0;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_stage_skid_sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with clear; clear wins over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Generic valid/ready inter-stage register with a two-entry
//                skid buffer, synchronous flush and saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 10,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int                ENT_W     = CTRL_W + DATA_W;
    localparam logic [ENT_W-1:0]  c_NOP_ENT = {NOP_CTRL, {DATA_W{1'b0}}};

    occ_state_t       r_state, w_state_nxt;
    logic [ENT_W-1:0] r_main, w_main_nxt;
    logic [ENT_W-1:0] r_skid, w_skid_nxt;
    logic             r_skid_valid, w_skid_valid_nxt;

    logic             w_acc;
    logic             w_drn;
    logic [ENT_W-1:0] w_in_ent;
    logic [ENT_W-1:0] w_bubble_ent;

    assign w_in_ent     = {in_ctrl, in_data};
    // A bubble keeps the stale data field; only control is forced to NOP
    assign w_bubble_ent = {NOP_CTRL, r_main[DATA_W-1:0]};

    assign in_ready  = !r_skid_valid && !rst;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main[DATA_W-1:0];
    assign out_ctrl  = out_valid ? r_main[ENT_W-1:DATA_W] : NOP_CTRL;
    assign occupancy = r_state;

    assign w_acc = in_valid && in_ready;
    assign w_drn = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_main       <= c_NOP_ENT;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;

        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_main_nxt       = w_bubble_ent;
            w_skid_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = w_in_ent;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_drn) begin
                        w_main_nxt = w_in_ent;
                    end else if (w_acc) begin
                        w_state_nxt      = ST_TWO;
                        w_skid_nxt       = w_in_ent;
                        w_skid_valid_nxt = 1'b1;
                    end else if (w_drn) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = w_bubble_ent;
                    end
                end
                ST_TWO: begin
                    if (w_drn) begin
                        w_state_nxt      = ST_ONE;
                        w_main_nxt       = r_skid;
                        w_skid_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt      = ST_EMPTY;
                    w_main_nxt       = w_bubble_ent;
                    w_skid_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule : pipe_stage_skid

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Directed self-checking bench for pipe_stage_skid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    localparam int               DATA_W = 16;
    localparam int               CTRL_W = 4;
    localparam logic [CTRL_W-1:0] NOP   = 4'hA;
    localparam int               CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_CTRL (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [CTRL_W-1:0] cx(input logic [DATA_W-1:0] d);
        return d[3:0] ^ 4'h3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = cx(d);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
        push(16'h0077);

        // Reset held two cycles with upstream offering data
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_ctrl", out_ctrl, NOP);
            chk("rst_out_data", out_data, 0);
            chk("rst_occ", occupancy, 0);
            chk("rst_cnt", stall_cnt, 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();
        chk("idle_occ", occupancy, 0);
        chk("idle_in_ready", in_ready, 1);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(DATA_W'(i));
            tick();
            chk("strm_valid", out_valid, 1);
            chk("strm_data", out_data, i);
            chk("strm_ctrl", out_ctrl, cx(DATA_W'(i)));
            chk("strm_occ", occupancy, 1);
            chk("strm_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("strm_end_valid", out_valid, 0);
        chk("strm_end_ctrl", out_ctrl, NOP);
        chk("strm_end_occ", occupancy, 0);
        chk("strm_cnt", stall_cnt, 0);

        // Backpressure fills skid, then drains in order
        out_ready = 1'b0;
        push(16'h000A);
        tick();
        chk("bp_occ1", occupancy, 1);
        chk("bp_data_a", out_data, 16'h000A);
        push(16'h000B);
        tick();
        chk("bp_occ2", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        push(16'h000C);
        tick();
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_hold_data", out_data, 16'h000A);
        chk("bp_cnt2", stall_cnt, 2);
        out_ready = 1'b1;
        tick();
        chk("bp_data_b", out_data, 16'h000B);
        chk("bp_ctrl_b", out_ctrl, cx(16'h000B));
        chk("bp_occ_b", occupancy, 1);
        chk("bp_in_ready_b", in_ready, 1);
        tick();
        chk("bp_data_c", out_data, 16'h000C);
        chk("bp_occ_c", occupancy, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", occupancy, 0);
        chk("bp_cnt_final", stall_cnt, 2);

        // Flush with two held and a pending push of 0xD
        out_ready = 1'b0;
        push(16'h0011);
        tick();
        push(16'h0012);
        tick();
        chk("fl_pre_occ", occupancy, 2);
        push(16'h000D);
        flush = 1'b1;
        tick();
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, NOP);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_cnt", stall_cnt, 4);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_no_d_valid", out_valid, 0);
        chk("fl_no_d_occ", occupancy, 0);

        // Simultaneous accept and drain while holding one
        out_ready = 1'b0;
        push(16'h0005);
        tick();
        chk("sim_data5", out_data, 16'h0005);
        out_ready = 1'b1;
        push(16'h0006);
        tick();
        chk("sim_data6", out_data, 16'h0006);
        chk("sim_occ", occupancy, 1);
        in_valid = 1'b0;
        tick();
        chk("sim_occ0", occupancy, 0);

        // Counter saturation and clear
        cnt_clr = 1'b1;
        tick();
        chk("cnt_clr0", stall_cnt, 0);
        cnt_clr = 1'b0;
        out_ready = 1'b0;
        push(16'h0021);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("cnt_14", stall_cnt, 14);
        tick();
        chk("cnt_15", stall_cnt, 15);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_sat", stall_cnt, 15);
        chk("cnt_hold_valid", out_valid, 1);
        cnt_clr = 1'b1;
        tick();
        chk("cnt_clr_stall", stall_cnt, 0);
        cnt_clr = 1'b0;
        tick();
        chk("cnt_resume", stall_cnt, 1);

        // Reset mid-transfer discards the held entry
        rst = 1'b1;
        tick();
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_cnt", stall_cnt, 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipe_stage_skid

`default_nettype wire
